// File: rtl/dec_unbinder_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_unbinder_seq_if                                                        |
// | Frame control plus in/out valid-ready streams of the sequential unbinder.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface dec_unbinder_seq_if #(
  parameter int HV_DIM       = 1024,
  parameter int NUM_FEATURES = 64
);
  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  logic              start_decoding;
  logic              in_valid;
  logic              in_ready;
  logic [HV_DIM-1:0] in_hv;
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] out_hv;
  logic [IDX_W-1:0]  out_feat_idx;
  logic              out_last;
  logic              done;
  logic              busy;

  modport master (
    output start_decoding, in_valid, in_hv, out_ready,
    input  in_ready, out_valid, out_hv, out_feat_idx, out_last, done, busy
  );

  modport slave (
    input  start_decoding, in_valid, in_hv, out_ready,
    output in_ready, out_valid, out_hv, out_feat_idx, out_last, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/dec_unbinder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_unbinder_seq                                                           |
// | Undoes encoder binding: rotates each feature's HV right by its shift.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dec_unbinder_seq #(
  parameter int HV_DIM          = 1024,
  parameter int NUM_FEATURES    = 64,
  parameter int SHIFT_BASE      = 0,
  parameter int SHIFT_TABLE_LEN = SHIFT_BASE + NUM_FEATURES,
  parameter logic [SHIFT_TABLE_LEN-1:0][31:0] SHIFTS = '0
) (
  input wire logic         clk,
  input wire logic         nrst,
  dec_unbinder_seq_if.slave bus
);
  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int SH_W  = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              s1_valid_q, s1_valid_d;
  logic [HV_DIM-1:0] s1_hv_q, s1_hv_d;
  logic [SH_W-1:0]   s1_shift_q, s1_shift_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic              s1_last_q, s1_last_d;
  logic              s2_valid_q, s2_valid_d;
  logic [HV_DIM-1:0] s2_hv_q, s2_hv_d;
  logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;
  logic              s2_last_q, s2_last_d;
  logic              done_q, done_d;

  logic                s2_free;
  logic                stall;
  logic                in_ready;
  logic                accept;
  logic                out_hs;
  logic [2*HV_DIM-1:0] dbl_hv;
  logic [HV_DIM-1:0]   rot_hv;

  // Shift table is constant, so the modulo folds away at elaboration.
  logic [SH_W-1:0] shift_tab [NUM_FEATURES];
  for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_shift_tab
    assign shift_tab[g] = SH_W'(SHIFTS[SHIFT_BASE + g] % HV_DIM);
  end

  always_comb begin
    s2_free  = !s2_valid_q || bus.out_ready;
    stall    = s1_valid_q && s2_valid_q && !bus.out_ready;
    in_ready = (state_q == ST_RUN) && !stall;
    accept   = bus.in_valid && in_ready;
    out_hs   = s2_valid_q && bus.out_ready;
    // Right rotation: bit j of the result is hv[(j+shift) mod HV_DIM].
    dbl_hv   = {s1_hv_q, s1_hv_q};
    rot_hv   = HV_DIM'(dbl_hv >> s1_shift_q);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s1_valid_d = s1_valid_q;
    s1_hv_d    = s1_hv_q;
    s1_shift_d = s1_shift_q;
    s1_idx_d   = s1_idx_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_hv_d    = s2_hv_q;
    s2_idx_d   = s2_idx_q;
    s2_last_d  = s2_last_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE:  if (bus.start_decoding) state_d = ST_RUN;
      ST_RUN:   if (accept && (idx_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: if (out_hs && s2_last_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (accept) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_hv_d    = bus.in_hv;
        s1_shift_d = shift_tab[idx_q];
        s1_idx_d   = idx_q;
        s1_last_d  = (idx_q == LAST_IDX);
      end
    end

    // S2 data only moves when a real beat arrives, keeping out_* steady otherwise.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_hv_d   = rot_hv;
        s2_idx_d  = s1_idx_q;
        s2_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_hv_q    <= '0;
      s1_shift_q <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_hv_q    <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_hv_q    <= s1_hv_d;
      s1_shift_q <= s1_shift_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_hv_q    <= s2_hv_d;
      s2_idx_q   <= s2_idx_d;
      s2_last_q  <= s2_last_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_hv       = s2_hv_q;
  assign bus.out_feat_idx = s2_idx_q;
  assign bus.out_last     = s2_last_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
endmodule
`default_nettype wire

// File: tb/tb_dec_unbinder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dec_unbinder_seq                                                        |
// | Scoreboard bench: small 8-bit instance for directed frames, 1024-bit one.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dec_unbinder_seq;
  localparam int SD = 8;
  localparam int SN = 4;
  localparam int BD = 1024;
  localparam int BN = 64;
  localparam int BB = 3;
  localparam int W  = 1024;

  typedef logic [W-1:0] hv_t;
  typedef struct {
    hv_t  hv;
    int   idx;
    logic last;
  } exp_t;

  function automatic logic [BN+BB-1:0][31:0] gen_shifts();
    logic [BN+BB-1:0][31:0] t;
    for (int i = 0; i < BN + BB; i++) t[i] = 32'(i * 97 + 13 * i * i);
    t[BB+0] = 32'd0;
    t[BB+1] = 32'd1024;
    t[BB+2] = 32'd2049;
    t[BB+3] = 32'd1023;
    return t;
  endfunction

  localparam logic [SN-1:0][31:0]    S_SHIFTS = {32'd8, 32'd7, 32'd0, 32'd3};
  localparam logic [BN+BB-1:0][31:0] B_SHIFTS = gen_shifts();

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  dec_unbinder_seq_if #(.HV_DIM(SD), .NUM_FEATURES(SN)) s_if ();
  dec_unbinder_seq_if #(.HV_DIM(BD), .NUM_FEATURES(BN)) b_if ();

  dec_unbinder_seq #(
    .HV_DIM(SD), .NUM_FEATURES(SN), .SHIFT_BASE(0),
    .SHIFT_TABLE_LEN(SN), .SHIFTS(S_SHIFTS)
  ) u_small (.clk(clk), .nrst(nrst), .bus(s_if));

  dec_unbinder_seq #(
    .HV_DIM(BD), .NUM_FEATURES(BN), .SHIFT_BASE(BB),
    .SHIFT_TABLE_LEN(BN + BB), .SHIFTS(B_SHIFTS)
  ) u_big (.clk(clk), .nrst(nrst), .bus(b_if));

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sq[$];
  exp_t bq[$];
  int   s_hs_cyc[$];
  int   s_feat = 0, b_feat = 0;
  int   s_acc = 0, s_acc_cyc = 0;
  int   s_done_cnt = 0, b_done_cnt = 0;
  logic s_done_exp = 1'b0, b_done_exp = 1'b0;
  logic chk_rst = 1'b0;
  logic b_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic hv_t rotr(input hv_t v, input int s, input int d);
    hv_t r = '0;
    for (int j = 0; j < d; j++) r[j] = v[(j + s) % d];
    return r;
  endfunction

  function automatic hv_t rotl(input hv_t v, input int s, input int d);
    hv_t r = '0;
    for (int j = 0; j < d; j++) r[(j + s) % d] = v[j];
    return r;
  endfunction

  function automatic hv_t rand_hv();
    hv_t r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic cmp(input string nm, input hv_t act, input hv_t exp);
    n_vec++;
    if (act !== exp) begin
      int w = 0;
      for (int k = W / 64 - 1; k >= 0; k--)
        if (act[k*64 +: 64] !== exp[k*64 +: 64]) w = k;
      n_err++;
      $display("FAIL %s: actual %h required %h (64-bit word %0d)", nm,
               act[w*64 +: 64], exp[w*64 +: 64], w);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Small-instance monitor, including the post-reset all-zero check.
  always @(negedge clk) begin
    if (chk_rst) begin
      cmp("rst_out_valid", hv_t'(s_if.out_valid), '0);
      cmp("rst_out_hv", hv_t'(s_if.out_hv), '0);
      cmp("rst_out_feat_idx", hv_t'(s_if.out_feat_idx), '0);
      cmp("rst_out_last", hv_t'(s_if.out_last), '0);
      cmp("rst_done", hv_t'(s_if.done), '0);
      cmp("rst_busy", hv_t'(s_if.busy), '0);
      cmp("rst_in_ready", hv_t'(s_if.in_ready), '0);
    end
    chk_rst = nrst;
    if (nrst) begin
      sq.delete();
      s_done_exp = 1'b0;
    end else begin
      cmp("s_done", hv_t'(s_if.done), hv_t'(s_done_exp));
      if (s_if.done) s_done_cnt++;
      s_done_exp = 1'b0;
      if (s_if.out_valid) begin
        if (sq.size() == 0) begin
          timeout_fail("s_unexpected_beat");
        end else begin
          cmp("s_out_hv", hv_t'(s_if.out_hv), sq[0].hv);
          cmp("s_out_feat_idx", hv_t'(s_if.out_feat_idx), hv_t'(sq[0].idx));
          cmp("s_out_last", hv_t'(s_if.out_last), hv_t'(sq[0].last));
          if (s_if.out_ready) begin
            s_hs_cyc.push_back(cyc);
            s_done_exp = sq[0].last;
            void'(sq.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      bq.delete();
      b_done_exp = 1'b0;
    end else begin
      cmp("b_done", hv_t'(b_if.done), hv_t'(b_done_exp));
      if (b_if.done) b_done_cnt++;
      b_done_exp = 1'b0;
      if (b_if.out_valid) begin
        if (bq.size() == 0) begin
          timeout_fail("b_unexpected_beat");
        end else begin
          cmp("b_out_hv", b_if.out_hv, bq[0].hv);
          cmp("b_out_feat_idx", hv_t'(b_if.out_feat_idx), hv_t'(bq[0].idx));
          cmp("b_out_last", hv_t'(b_if.out_last), hv_t'(bq[0].last));
          if (b_if.out_ready) begin
            b_done_exp = bq[0].last;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_start();
    s_if.start_decoding = 1'b1;
    tick();
    s_if.start_decoding = 1'b0;
  endtask

  task automatic b_start();
    b_if.start_decoding = 1'b1;
    tick();
    b_if.start_decoding = 1'b0;
  endtask

  task automatic s_send(input hv_t v);
    int  k = 0;
    bit  ok = 0;
    s_if.in_valid = 1'b1;
    s_if.in_hv    = v[SD-1:0];
    while (!ok && k < 200) begin
      @(negedge clk);
      if (s_if.in_ready) begin
        sq.push_back('{hv: rotr(v, int'(S_SHIFTS[s_feat] % SD), SD),
                       idx: s_feat, last: (s_feat == SN - 1)});
        s_acc_cyc = cyc;
        s_acc++;
        s_feat = (s_feat + 1) % SN;
        ok = 1;
      end
      tick();
      k++;
    end
    if (!ok) timeout_fail("s_accept");
    s_if.in_valid = 1'b0;
  endtask

  task automatic b_send(input hv_t lvl);
    int k = 0;
    bit ok = 0;
    int s = int'(B_SHIFTS[BB + b_feat] % BD);
    b_if.in_valid = 1'b1;
    b_if.in_hv    = rotl(lvl, s, BD);
    while (!ok && k < 200) begin
      @(negedge clk);
      if (b_if.in_ready) begin
        bq.push_back('{hv: lvl, idx: b_feat, last: (b_feat == BN - 1)});
        b_feat = (b_feat + 1) % BN;
        ok = 1;
      end
      tick();
      k++;
    end
    if (!ok) timeout_fail("b_accept");
    b_if.in_valid = 1'b0;
  endtask

  task automatic s_wait_idle();
    int k = 0;
    while ((s_if.busy || sq.size() != 0 || s_done_exp) && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) timeout_fail("s_frame_drain");
    tick();
  endtask

  task automatic b_wait_idle();
    int k = 0;
    while ((b_if.busy || bq.size() != 0 || b_done_exp) && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) timeout_fail("b_frame_drain");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      tick();
      if (b_rand) b_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int d0, a0, acc0;
    s_if.start_decoding = 1'b0; s_if.in_valid = 1'b0; s_if.in_hv = '0; s_if.out_ready = 1'b1;
    b_if.start_decoding = 1'b0; b_if.in_valid = 1'b0; b_if.in_hv = '0; b_if.out_ready = 1'b1;
    repeat (3) tick();
    nrst = 1'b0;
    tick();

    // Fixed shifts {3,0,7,8} on 8-bit HVs, back-to-back at full rate.
    d0 = s_done_cnt;
    s_hs_cyc.delete();
    s_start();
    a0 = 0;
    for (int i = 0; i < SN; i++) begin
      s_send(hv_t'(8'h01));
      if (i == 0) a0 = s_acc_cyc;
    end
    s_wait_idle();
    cmp("t1_done_count", hv_t'(s_done_cnt - d0), hv_t'(1));
    cmp("t2_beat_count", hv_t'(s_hs_cyc.size()), hv_t'(SN));
    if (s_hs_cyc.size() == SN) begin
      cmp("t2_first_latency", hv_t'(s_hs_cyc[0] - a0), hv_t'(2));
      for (int k = 1; k < SN; k++)
        cmp("t2_consecutive", hv_t'(s_hs_cyc[k] - s_hs_cyc[k-1]), hv_t'(1));
    end

    // Downstream stalled from frame start: pipe fills with two beats then in_ready drops.
    s_start();
    s_if.out_ready = 1'b0;
    acc0 = s_acc;
    fork
      for (int i = 0; i < SN; i++) s_send(hv_t'($urandom_range(0, 255)));
      begin
        repeat (5) tick();
        cmp("t3_in_ready_stalled", hv_t'(s_if.in_ready), '0);
        cmp("t3_accepted_while_stalled", hv_t'(s_acc - acc0), hv_t'(2));
        s_if.out_ready = 1'b1;
      end
    join
    s_wait_idle();

    // in_valid held in IDLE, then a redundant start mid-frame.
    d0 = s_done_cnt;
    acc0 = s_acc;
    fork
      for (int i = 0; i < SN; i++) s_send(hv_t'($urandom_range(0, 255)));
      begin
        repeat (3) begin
          tick();
          cmp("t4_idle_in_ready", hv_t'(s_if.in_ready), '0);
          cmp("t4_idle_no_accept", hv_t'(s_acc - acc0), '0);
        end
        s_start();
        tick();
        s_start();
      end
    join
    s_wait_idle();
    repeat (2) tick();
    cmp("t4_one_done", hv_t'(s_done_cnt - d0), hv_t'(1));
    cmp("t4_idle_after", hv_t'(s_if.busy), '0);

    // Reset after two accepted beats; next frame restarts at feature 0.
    d0 = s_done_cnt;
    s_start();
    for (int i = 0; i < 2; i++) s_send(hv_t'($urandom_range(0, 255)));
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    s_feat = 0;
    b_feat = 0;
    s_start();
    for (int i = 0; i < SN; i++) s_send(hv_t'($urandom_range(0, 255)));
    s_wait_idle();
    cmp("t5_done_after_reset", hv_t'(s_done_cnt - d0), hv_t'(1));

    // 1024-bit encode/decode round trip with random gaps and backpressure.
    b_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      d0 = b_done_cnt;
      b_start();
      for (int i = 0; i < BN; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        b_send(rand_hv());
      end
      b_wait_idle();
      cmp("t6_done_count", hv_t'(b_done_cnt - d0), hv_t'(1));
    end
    b_rand = 1'b0;
    b_if.out_ready = 1'b1;
    repeat (3) tick();

    cmp("s_scoreboard_empty", hv_t'(sq.size()), '0);
    cmp("b_scoreboard_empty", hv_t'(bq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
